// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit, one step per clock.
// Define MULDIV_SIGNED_EN to add the signed_in port and two's-complement ops.
module muldiv_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef MULDIV_SIGNED_EN
    input  logic             signed_in,
`endif
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic [4:0]       flags_out,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             sgn_q, sgn_d;
    logic             neg_q, neg_d;
    logic             sovf_q, sovf_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [4:0]       flags_q, flags_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic               sgn_in, accept, is_div, dge, ovf;
    logic [WIDTH-1:0]   a_mag, b_mag, src_hi, src_lo, src_opnd;
    logic [WIDTH-1:0]   it_hi, it_lo, qv, rv, res;
    logic [WIDTH:0]     msum, dsh;
    logic [2*WIDTH-1:0] prod, sprod;

    function automatic logic [4:0] mk_flags(input logic [WIDTH-1:0] r,
                                            input logic v);
        return {^r, v, r[WIDTH-1], 1'b0, ~|r};
    endfunction

    always_comb begin
`ifdef MULDIV_SIGNED_EN
        sgn_in = signed_in;
`else
        sgn_in = 1'b0;
`endif
        accept = start && (state_q != RUN);
        a_mag  = (sgn_in && a_in[WIDTH-1]) ? -a_in : a_in;
        b_mag  = (sgn_in && b_in[WIDTH-1]) ? -b_in : b_in;

        // The accept edge performs the first step straight from the inputs.
        is_div   = accept ? op[1] : op_q[1];
        src_hi   = accept ? '0 : hi_q;
        src_lo   = accept ? (op[1] ? a_mag : b_mag) : lo_q;
        src_opnd = accept ? (op[1] ? b_mag : a_mag) : opnd_q;

        msum = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_opnd} : '0);
        dsh  = {src_hi, src_lo[WIDTH-1]};
        dge  = dsh >= {1'b0, src_opnd};
        if (is_div) begin
            it_hi = dge ? (dsh[WIDTH-1:0] - src_opnd) : dsh[WIDTH-1:0];
            it_lo = {src_lo[WIDTH-2:0], dge};
        end else begin
            it_hi = msum[WIDTH:1];
            it_lo = {msum[0], src_lo[WIDTH-1:1]};
        end

        prod  = {it_hi, it_lo};
        sprod = neg_q ? -prod : prod;
        qv    = neg_q ? -it_lo : it_lo;
        rv    = neg_q ? -it_hi : it_hi;
        res   = '0;
        ovf   = 1'b0;
        case (op_q)
            2'b00: begin
                res = sprod[WIDTH-1:0];
                ovf = sgn_q ? (sprod[2*WIDTH-1:WIDTH] != {WIDTH{sprod[WIDTH-1]}})
                            : (|sprod[2*WIDTH-1:WIDTH]);
            end
            2'b01: res = sprod[2*WIDTH-1:WIDTH];
            2'b10: begin
                res = qv;
                ovf = sovf_q;
            end
            default: res = rv;
        endcase

        state_d = state_q;
        op_d    = op_q;
        sgn_d   = sgn_q;
        neg_d   = neg_q;
        sovf_d  = sovf_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        flags_d = flags_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        case (state_q)
            RUN: begin
                hi_d  = it_hi;
                lo_d  = it_lo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_d == '0) begin
                    out_d   = res;
                    flags_d = mk_flags(res, ovf);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FIN;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (accept) begin
                    op_d   = op;
                    sgn_d  = sgn_in;
                    dbz_d  = 1'b0;
                    hi_d   = it_hi;
                    lo_d   = it_lo;
                    opnd_d = src_opnd;
                    cnt_d  = CW'(WIDTH - 1);
                    neg_d  = sgn_in && ((op == 2'b11) ? a_in[WIDTH-1]
                                        : (a_in[WIDTH-1] ^ b_in[WIDTH-1]));
                    sovf_d = sgn_in && (op == 2'b10) && (a_in == MINV) && (&b_in);
                    if (op[1] && (b_in == '0)) begin
                        out_d   = op[0] ? a_in : '1;
                        flags_d = mk_flags(out_d, 1'b1);
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            sovf_q  <= 1'b0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
            sovf_q  <= sovf_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign out         = out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign flags_out   = flags_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random stimulus for muldiv_unit against an arithmetic model.
// Latency is counted in cycles, the accept cycle being cycle 1.
module tb_muldiv_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op_i = '0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
`ifdef MULDIV_SIGNED_EN
    logic         sgn_i = 1'b0;
`endif
    logic [W-1:0] out;
    logic         busy, done, dbz;
    logic [4:0]   flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .op(op_i),
        .a_in(a_i),
        .b_in(b_i),
`ifdef MULDIV_SIGNED_EN
        .signed_in(sgn_i),
`endif
        .out(out),
        .busy(busy),
        .done(done),
        .flags_out(flags),
        .div_by_zero(dbz)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  input bit s, output logic [W-1:0] o,
                                  output logic [4:0] f, output bit dz);
        longint pa, pb, p;
        logic v;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        p  = pa * pb;
        dz = op[1] && (b == '0);
        v  = 1'b0;
        o  = '0;
        case (op)
            2'b00: begin
                o = p[W-1:0];
                v = s ? (p != longint'($signed(o))) : ((p >> W) != 0);
            end
            2'b01: o = p[2*W-1:W];
            2'b10: begin
                if (dz) begin
                    o = '1;
                    v = 1'b1;
                end else if (s && pa == -32768 && pb == -1) begin
                    o = 16'h8000;
                    v = 1'b1;
                end else begin
                    o = W'(pa / pb);
                end
            end
            default: begin
                if (dz) begin
                    o = a;
                    v = 1'b1;
                end else begin
                    o = W'(pa % pb);
                end
            end
        endcase
        f = {^o, v, o[W-1], 1'b0, o == '0};
    endfunction

    // Leaves the bench at the falling edge of the cycle in which done is high.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit s, input bit b2b,
                          input bit poke, input string tag);
        logic [W-1:0] eo;
        logic [4:0]   ef;
        bit           edz;
        int           n;
        if (!b2b) @(negedge clk);
        start = 1'b1;
        op_i  = op;
        a_i   = a;
        b_i   = b;
`ifdef MULDIV_SIGNED_EN
        sgn_i = s;
`endif
        n = 1;
        @(negedge clk);
        n++;
        start = 1'b0;
        op_i  = 2'($urandom);
        a_i   = W'($urandom);
        b_i   = W'($urandom);
        while (!done && n < 40) begin
            start = poke && (n == 5);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        model(op, a, b, s, eo, ef, edz);
        chk({tag, "/lat"}, 32'(n), edz ? 32'd2 : 32'(W + 1));
        chk({tag, "/out"}, 32'(out), 32'(eo));
        chk({tag, "/flags"}, 32'(flags), 32'(ef));
        chk({tag, "/dbz"}, 32'(dbz), 32'(edz));
        chk({tag, "/busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int dcount;
        logic [W-1:0] rb;

        repeat (3) @(negedge clk);
        chk("rst/out", 32'(out), 32'd0);
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/done", 32'(done), 32'd0);
        chk("rst/flags", 32'(flags), 32'd0);
        chk("rst/dbz", 32'(dbz), 32'd0);
        rst_n = 1'b1;

        @(negedge clk);
        start = 1'b1;
        op_i  = 2'b00;
        a_i   = 16'd3;
        b_i   = 16'd5;
        @(negedge clk);
        start = 1'b0;
        chk("abort/busy_run", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort/busy", 32'(busy), 32'd0);
        chk("abort/out", 32'(out), 32'd0);
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort/no_done", 32'(dcount), 32'd0);

        run_op(2'b00, 16'h1234, 16'h0010, 1'b0, 1'b0, 1'b0, "mullo");
        chk("mullo/val", 32'(out), 32'h2340);
        chk("mullo/ovf", 32'(flags[3]), 32'd1);
        @(negedge clk);
        chk("mullo/pulse", 32'(done), 32'd0);
        chk("mullo/hold", 32'(out), 32'h2340);

        run_op(2'b01, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, "mulhi");
        chk("mulhi/val", 32'(out), 32'hFFFE);
        run_op(2'b00, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, "b2b");
        chk("b2b/val", 32'(out), 32'h0001);

        run_op(2'b10, 16'd100, 16'd7, 1'b0, 1'b0, 1'b0, "divq");
        chk("divq/val", 32'(out), 32'd14);
        run_op(2'b11, 16'd100, 16'd7, 1'b0, 1'b0, 1'b0, "divr");
        chk("divr/val", 32'(out), 32'd2);
        run_op(2'b11, 16'd7, 16'd7, 1'b0, 1'b0, 1'b0, "divr0");
        chk("divr0/zero", 32'(flags[0]), 32'd1);

        run_op(2'b10, 16'h55AA, 16'h0000, 1'b0, 1'b0, 1'b0, "dz_q");
        chk("dz_q/val", 32'(out), 32'hFFFF);
        run_op(2'b11, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, "dz_r");
        run_op(2'b10, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, "dz_clr");

        run_op(2'b00, 16'h00FF, 16'h0101, 1'b0, 1'b0, 1'b1, "poke");
        chk("poke/val", 32'(out), 32'hFFFF);

`ifdef MULDIV_SIGNED_EN
        run_op(2'b10, 16'hFFF9, 16'd2, 1'b1, 1'b0, 1'b0, "s_divq");
        chk("s_divq/val", 32'(out), 32'hFFFD);
        run_op(2'b11, 16'hFFF9, 16'd2, 1'b1, 1'b0, 1'b0, "s_divr");
        chk("s_divr/val", 32'(out), 32'hFFFF);
        run_op(2'b10, 16'h8000, 16'hFFFF, 1'b1, 1'b0, 1'b0, "s_min");
        chk("s_min/ovf", 32'(flags[3]), 32'd1);
        for (int i = 0; i < 20; i++) begin
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_op(2'($urandom), W'($urandom), rb, 1'b1,
                   1'($urandom), 1'b0, "s_rnd");
        end
`endif

        for (int i = 0; i < 30; i++) begin
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if (i % 5 == 0) rb = W'($urandom_range(1, 15));
            run_op(2'($urandom), W'($urandom), rb, 1'b0,
                   1'($urandom), 1'b0, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide execution unit.
- Sits beside the single-cycle ALU in the execute stage and takes the same operand buses.
- Its result and 5-bit flag word feed the same writeback/flags mux downstream, covering the MUL/DIV opcodes that the ALU does not implement.
- Uses one radix-2 shift-add (multiply) or restoring-subtract (divide) step per clock.

Parameters:
- WIDTH, 16, operand/result width; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- start  input  1  request; accepted only when busy=0.
- op  input  2  00 MULLO, 01 MULHI, 10 DIVQ (quotient), 11 DIVR (remainder).
- a_in  input  WIDTH  multiplicand / dividend; sampled at accept.
- b_in  input  WIDTH  multiplier / divisor; sampled at accept.
- out  output  WIDTH  result; held stable from done until the next accept.
- busy  output  1  high while an operation is in flight.
- done  output  1  single-cycle pulse when out/flags_out become valid.
- flags_out  output  5  {PAR,OVF,NEG,CARRY,ZERO}, bit order identical to the ALU flags word.
- div_by_zero  output  1  sticky until the next accept; set when a DIV op has b=0.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; out=0, flags_out=0, busy=0, done=0, div_by_zero=0; internal accumulators and counter cleared. Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, RUN, FIN.
- IDLE/FIN + start=1: latch op, a, b; counter=WIDTH-1; busy=1 next cycle; go to RUN.
  - Exception: DIV with b=0 goes directly to FIN.
- RUN: one iteration per cycle.
  - When counter=0, write results and go to FIN.
  - Total latency from the accept edge to the done edge is WIDTH+1 cycles (17 for WIDTH=16).
- FIN: done=1 for exactly one cycle; busy=0; out/flags_out hold. Then go to IDLE (outputs still held). A start in FIN is accepted like IDLE, giving back-to-back operation.
- start while busy=1 is ignored; latched operands are unaffected.
- Multiply: 2*WIDTH-bit unsigned product P.
  - MULLO: out=P[WIDTH-1:0]; OVF = |P[2WIDTH-1:WIDTH].
  - MULHI: out=P[2WIDTH-1:WIDTH]; OVF=0.
- Divide: restoring, unsigned. DIVQ: out=a/b. DIVR: out=a%b. OVF=0.
- Divide by zero: done on the cycle after accept (latency 2).
  - Quotient = all ones; remainder = a.
  - div_by_zero=1, OVF=1.
- Flags, computed on the final out value:
  - ZERO = ~|out.
  - CARRY = 0 always.
  - NEG = out[WIDTH-1].
  - PAR = ^out.
- flags_out updates only with done. There is no separate enable; the flags mux downstream selects.

Optional Feature:
- MULDIV_SIGNED_EN defined:
  - Extra input signed_in (1 bit), sampled at accept.
  - When signed_in=1, operands are two's-complement: convert to magnitudes, run the same unsigned core, then negate the result.
  - Product sign = a^b. Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - MULLO OVF = upper half is not the sign-extension of the lower half.
  - DIVQ of most-negative by -1: out=most-negative, OVF=1.
  - Latency is unchanged (sign fix is folded into the FIN write).
- MULDIV_SIGNED_EN undefined: signed_in port is absent and all ops are unsigned.

Test Plan:
- Reset mid-RUN: start MULLO a=3 b=5, assert rst_n=0 on cycle 4 -> no done; busy=0 and out=0 after that edge.
- MULLO a=0x1234 b=0x0010 -> done exactly 17 cycles after the accept edge; out=0x2340; OVF=1 (P=0x00012340); ZERO=0; PAR=^0x2340.
- MULHI a=0xFFFF b=0xFFFF -> out=0xFFFE; NEG=1. Back-to-back: start asserted in the FIN cycle, MULLO same operands -> out=0x0001.
- DIVQ a=100 b=7 -> out=14. DIVR a=100 b=7 -> out=2. DIVR a=7 b=7 -> out=0, ZERO=1.
- DIVQ a=0x55AA b=0 -> done 2 cycles after accept; out=0xFFFF; div_by_zero=1; OVF=1. Next accept clears div_by_zero.
- start pulsed while busy with a different a/b -> ignored; the first operation's result is unchanged.
- With MULDIV_SIGNED_EN:
  - DIVQ signed a=-7 b=2 -> out=0xFFFD (-3).
  - DIVR signed a=-7 b=2 -> out=0xFFFF (-1).
  - DIVQ signed a=0x8000 b=0xFFFF -> out=0x8000, OVF=1.
